// File: rtl/fila_scheduler_if.sv
// fila_scheduler_if
//   Bundles the deserializer/consumer handshakes, the FIFO occupancy input and
//   the scheduler's strobes and status lines.
//   master : the scheduler side (drives strobes, status, stall count)
//   slave  : the environment side (deserializer, consumer, fila occupancy)
// Signals:
//   data_ready, deq_req, len_in                      environment -> scheduler
//   enqueue_out, ack_out, dequeue_out, deq_grant,
//   full_out, empty_out, busy_out, stall_cnt_out     scheduler -> environment
interface fila_scheduler_if #(
  parameter int LEN_W = 4
);
  logic             data_ready;
  logic             deq_req;
  logic [LEN_W-1:0] len_in;
  logic             enqueue_out;
  logic             ack_out;
  logic             dequeue_out;
  logic             deq_grant;
  logic             full_out;
  logic             empty_out;
  logic             busy_out;
  logic [7:0]       stall_cnt_out;

  modport master (
    input  data_ready, deq_req, len_in,
    output enqueue_out, ack_out, dequeue_out, deq_grant,
           full_out, empty_out, busy_out, stall_cnt_out
  );

  modport slave (
    output data_ready, deq_req, len_in,
    input  enqueue_out, ack_out, dequeue_out, deq_grant,
           full_out, empty_out, busy_out, stall_cnt_out
  );
endinterface

// File: rtl/fila_scheduler.sv
// fila_scheduler
//   Sequences enqueue/dequeue transfers into the 8-entry fila FIFO and
//   arbitrates between the deserializer (enqueue) and the consumer (dequeue)
//   with round-robin fairness on ties. All outputs are registered.
// Ports:
//   clk_10KHz  clock, all state on the rising edge
//   reset      asynchronous, active-high
//   bus        fila_scheduler_if.master (handshakes, len_in, strobes, status)
// Optional feature macro: STALL_CNT_EN
//   defined   -> stall_cnt_out counts IDLE edges where a byte waits on a full
//                FIFO, saturating at 255, cleared only by reset
//   undefined -> stall_cnt_out tied to zero
//
// state  | meaning
// IDLE   | waiting; evaluates enq_ok/deq_ok each edge
// ENQ    | enqueue_out/ack_out high for this cycle
// DEQ    | dequeue_out/deq_grant high for this cycle
// SETTLE | strobes low; lets fila's len_in update before the next decision
module fila_scheduler #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 4
) (
  input logic             clk_10KHz,
  input logic             reset,
  fila_scheduler_if.master bus
);

  typedef enum logic [1:0] {IDLE, ENQ, DEQ, SETTLE} state_t;

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  state_t state;
  logic   ack_flag;
  logic   last_enq;   // 1: last grant went to enqueue, 0: to dequeue
  logic   is_full;
  logic   enq_ok;
  logic   deq_ok;
  logic   pick_enq;

  always_comb begin
    is_full  = (bus.len_in >= DEPTH_L);
    enq_ok   = bus.data_ready & ~ack_flag & ~is_full;
    deq_ok   = bus.deq_req & (bus.len_in != '0);
    // On a tie, serve the side that did not win last time.
    pick_enq = enq_ok & (~deq_ok | ~last_enq);
  end

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      ack_flag        <= 1'b0;
      last_enq        <= 1'b0;
      bus.enqueue_out <= 1'b0;
      bus.ack_out     <= 1'b0;
      bus.dequeue_out <= 1'b0;
      bus.deq_grant   <= 1'b0;
      bus.full_out    <= 1'b0;
      bus.empty_out   <= 1'b1;
      bus.busy_out    <= 1'b0;
    end else begin
      bus.enqueue_out <= 1'b0;
      bus.ack_out     <= 1'b0;
      bus.dequeue_out <= 1'b0;
      bus.deq_grant   <= 1'b0;
      bus.full_out    <= is_full;
      bus.empty_out   <= (bus.len_in == '0);

      case (state)
        IDLE: begin
          if (pick_enq) begin
            state           <= ENQ;
            bus.enqueue_out <= 1'b1;
            bus.ack_out     <= 1'b1;
            bus.busy_out    <= 1'b1;
            ack_flag        <= 1'b1;
            last_enq        <= 1'b1;
          end else if (deq_ok) begin
            state           <= DEQ;
            bus.dequeue_out <= 1'b1;
            bus.deq_grant   <= 1'b1;
            bus.busy_out    <= 1'b1;
            last_enq        <= 1'b0;
          end
        end
        ENQ, DEQ: begin
          state <= SETTLE;
        end
        SETTLE: begin
          state        <= IDLE;
          bus.busy_out <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          bus.busy_out <= 1'b0;
        end
      endcase

      // A dropped data_ready re-arms acceptance in any state, including the
      // ENQ cycle itself; this overrides the set above.
      if (!bus.data_ready) begin
        ack_flag <= 1'b0;
      end
    end
  end

`ifdef STALL_CNT_EN
  logic [7:0] stall_cnt;

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      stall_cnt <= 8'd0;
    end else if ((state == IDLE) && bus.data_ready && !ack_flag && is_full
                 && (stall_cnt != 8'hFF)) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

  assign bus.stall_cnt_out = stall_cnt;
`else
  assign bus.stall_cnt_out = 8'd0;
`endif

endmodule
